// File: rtl/snapshot_capture_ctrl.sv
// Snapshot capture controller: arm/trigger FSM that streams qualified samples into a 2^ADDR_W buffer; optional trigger offset under SNAPSHOT_CAPTURE_OFFSET_EN.
// Latency: a qualified sample appears on bram_we/bram_addr/bram_din one cycle after its sample cycle.
// Backpressure: none; the sample stream is never stalled, and capture stops once the buffer is full.
module snapshot_capture_ctrl #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 64
) (
  input  logic              user_clk,
  input  logic              user_rst,
  input  logic [31:0]       ctrl_reg,
  input  logic              trig_in,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] din,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_we,
  output logic [DATA_W-1:0] bram_din,
  output logic [31:0]       status_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_OFFSET,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            arm_prev;
  logic            hist_vld;
  logic            arm_edge;
  logic            trigger;
  logic            qual;
  logic            capture_sample;
  logic            count_last;
  logic            offset_req;
  logic            off_done;
  logic [ADDR_W:0] count;

  // hist_vld masks the first post-reset cycle so a level held through reset cannot arm
  assign arm_edge   = ctrl_reg[0] & ~arm_prev & hist_vld;
  assign trigger    = trig_in | ctrl_reg[1];
  assign qual       = ctrl_reg[2] ? data_valid : 1'b1;
  assign count_last = ~count[ADDR_W] & (count[ADDR_W-1:0] == {ADDR_W{1'b1}});

`ifdef SNAPSHOT_CAPTURE_OFFSET_EN
  logic [15:0] off_cnt;
  logic        unused_ctrl;

  assign offset_req  = (ctrl_reg[31:16] != 16'd0);
  assign off_done    = (off_cnt == 16'd0);
  assign unused_ctrl = &{1'b0, ctrl_reg[15:3]};

  // Loaded with N-1 at the trigger so the last OFFSET cycle is exactly N cycles after it
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      off_cnt <= '0;
    end else if (state == S_ARMED && trigger && !arm_edge) begin
      off_cnt <= ctrl_reg[31:16] - 16'd1;
    end else if (state == S_OFFSET && !off_done) begin
      off_cnt <= off_cnt - 16'd1;
    end
  end
`else
  logic unused_ctrl;

  assign offset_req  = 1'b0;
  assign off_done    = 1'b0;
  assign unused_ctrl = &{1'b0, ctrl_reg[31:3]};
`endif

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (arm_edge) begin
      state_nxt = S_ARMED;
    end else begin
      case (state)
        S_IDLE: state_nxt = S_IDLE;
        S_ARMED: begin
          if (trigger) begin
            if (offset_req) begin
              state_nxt = S_OFFSET;
            end else begin
              state_nxt = (capture_sample && count_last) ? S_DONE : S_CAPTURE;
            end
          end
        end
        S_OFFSET: begin
          if (off_done) begin
            state_nxt = (capture_sample && count_last) ? S_DONE : S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (capture_sample && count_last) begin
            state_nxt = S_DONE;
          end
        end
        S_DONE:  state_nxt = S_DONE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    capture_sample = 1'b0;
    status_out     = '0;
    case (state)
      S_ARMED: begin
        status_out[29] = 1'b1;
        capture_sample = trigger & ~offset_req & qual;
      end
      S_OFFSET: begin
        status_out[30] = 1'b1;
        capture_sample = off_done & qual;
      end
      S_CAPTURE: begin
        status_out[30] = 1'b1;
        capture_sample = qual;
      end
      S_DONE:  status_out[31] = 1'b1;
      default: ;
    endcase
    if (arm_edge) begin
      capture_sample = 1'b0;
    end
    status_out[ADDR_W:0] = count;
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      arm_prev  <= 1'b0;
      hist_vld  <= 1'b0;
      count     <= '0;
      bram_we   <= 1'b0;
      bram_addr <= '0;
      bram_din  <= '0;
    end else begin
      arm_prev <= ctrl_reg[0];
      hist_vld <= 1'b1;
      bram_we  <= capture_sample;
      if (arm_edge) begin
        count <= '0;
      end else if (capture_sample) begin
        count     <= count + {{ADDR_W{1'b0}}, 1'b1};
        bram_addr <= count[ADDR_W-1:0];
        bram_din  <= din;
      end
    end
  end

endmodule

// File: tb/tb_snapshot_capture_ctrl.sv
// Bench for snapshot_capture_ctrl: per-cycle vector table plus directed capture sequences, writes scored against a queue.
module tb_snapshot_capture_ctrl;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 64;

  logic              clk;
  logic              user_rst;
  logic [31:0]       ctrl_reg;
  logic              trig_in;
  logic              data_valid;
  logic [DATA_W-1:0] din;
  logic [ADDR_W-1:0] bram_addr;
  logic              bram_we;
  logic [DATA_W-1:0] bram_din;
  logic [31:0]       status_out;

  snapshot_capture_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .user_clk   (clk),
    .user_rst   (user_rst),
    .ctrl_reg   (ctrl_reg),
    .trig_in    (trig_in),
    .data_valid (data_valid),
    .din        (din),
    .bram_addr  (bram_addr),
    .bram_we    (bram_we),
    .bram_din   (bram_din),
    .status_out (status_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned       cyc;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dat;
  } exp_t;

  typedef struct {
    logic [31:0]       ctrl;
    logic              trig;
    logic              vld;
    logic [DATA_W-1:0] dat;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       st;
  } vec_t;

  exp_t        sb[$];
  vec_t        vt[16];
  int unsigned cyc_n = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc_n);
    end
  endfunction

  task automatic drive(input logic [31:0] c, input logic t, input logic v, input logic [DATA_W-1:0] d);
    ctrl_reg   = c;
    trig_in    = t;
    data_valid = v;
    din        = d;
  endtask

  // The write for a sample driven now must be visible right after the coming edge
  task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    sb.push_back('{cyc_n + 1, a, d});
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc_n++;
    if (bram_we) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: got write addr 0x%0h at cycle %0d, required no write", bram_addr, cyc_n);
      end else begin
        e = sb.pop_front();
        chk("wr_cycle", 64'(cyc_n), 64'(e.cyc));
        chk("wr_addr", 64'(bram_addr), 64'(e.addr));
        chk("wr_din", bram_din, e.dat);
      end
    end else if (sb.size() != 0 && sb[0].cyc <= cyc_n) begin
      e = sb.pop_front();
      chk("wr_missing_we", 64'(bram_we), 64'(1));
    end
  endtask

  initial begin
    vt[0]  = '{32'h0, 1'b0, 1'b0, 64'h0,  1'b0, 11'd0, 32'h0000_0000};
    vt[1]  = '{32'h1, 1'b0, 1'b0, 64'h0,  1'b0, 11'd0, 32'h2000_0000};
    vt[2]  = '{32'h1, 1'b0, 1'b0, 64'h0,  1'b0, 11'd0, 32'h2000_0000};
    vt[3]  = '{32'h0, 1'b0, 1'b0, 64'h0,  1'b0, 11'd0, 32'h2000_0000};
    vt[4]  = '{32'h1, 1'b1, 1'b1, 64'h9,  1'b0, 11'd0, 32'h2000_0000};
    vt[5]  = '{32'h1, 1'b0, 1'b1, 64'h9,  1'b0, 11'd0, 32'h2000_0000};
    vt[6]  = '{32'h5, 1'b1, 1'b0, 64'hAA, 1'b0, 11'd0, 32'h4000_0000};
    vt[7]  = '{32'h5, 1'b0, 1'b1, 64'h11, 1'b1, 11'd0, 32'h4000_0001};
    vt[8]  = '{32'h5, 1'b0, 1'b0, 64'hBB, 1'b0, 11'd0, 32'h4000_0001};
    vt[9]  = '{32'h5, 1'b0, 1'b1, 64'h22, 1'b1, 11'd1, 32'h4000_0002};
    vt[10] = '{32'h4, 1'b0, 1'b0, 64'hCC, 1'b0, 11'd0, 32'h4000_0002};
    vt[11] = '{32'h1, 1'b0, 1'b0, 64'hDD, 1'b0, 11'd0, 32'h2000_0000};
    vt[12] = '{32'h3, 1'b0, 1'b0, 64'h33, 1'b1, 11'd0, 32'h4000_0001};
    vt[13] = '{32'h1, 1'b0, 1'b0, 64'h44, 1'b1, 11'd1, 32'h4000_0002};
    vt[14] = '{32'h0, 1'b0, 1'b0, 64'h55, 1'b1, 11'd2, 32'h4000_0003};
    vt[15] = '{32'h1, 1'b0, 1'b0, 64'h66, 1'b0, 11'd0, 32'h2000_0000};

    user_rst = 1'b1;
    drive(32'h0, 1'b0, 1'b0, '0);
    repeat (3) tick();
    chk("rst_we", 64'(bram_we), 64'(0));
    chk("rst_addr", 64'(bram_addr), 64'(0));
    chk("rst_din", bram_din, 64'(0));
    chk("rst_status", 64'(status_out), 64'(0));
    user_rst = 1'b0;
    repeat (2) tick();

    // Arm edge, held level, trigger/arm priority, valid gating, force trigger
    for (int i = 0; i < 16; i++) begin
      drive(vt[i].ctrl, vt[i].trig, vt[i].vld, vt[i].dat);
      if (vt[i].wr) push(vt[i].addr, vt[i].dat);
      tick();
      chk($sformatf("vec%0d_we", i), 64'(bram_we), 64'(vt[i].wr));
      chk($sformatf("vec%0d_status", i), 64'(status_out), 64'(vt[i].st));
    end

    // Full capture from a one-cycle trig_in pulse with a ramp
    for (int i = 0; i < 2048; i++) begin
      drive(32'h1, (i == 0), 1'b1, 64'(i));
      push(11'(i), 64'(i));
      tick();
      if (i == 2046) chk("full_status_pre", 64'(status_out), 64'h4000_07FF);
    end
    chk("full_status_done", 64'(status_out), 64'h8000_0800);
    for (int i = 0; i < 3; i++) begin
      drive(32'h3, 1'b1, 1'b1, 64'hF00 + 64'(i));
      tick();
      chk("done_hold_status", 64'(status_out), 64'h8000_0800);
    end
    chk("done_hold_addr", 64'(bram_addr), 64'd2047);
    chk("done_hold_din", bram_din, 64'd2047);

    // Valid-gated capture with data_valid toggling
    drive(32'h0, 1'b0, 1'b0, '0);
    tick();
    chk("done_no_arm_on_low", 64'(status_out), 64'h8000_0800);
    drive(32'h5, 1'b0, 1'b0, '0);
    tick();
    chk("gate_armed", 64'(status_out), 64'h2000_0000);
    begin
      int n = 0;
      for (int i = 0; i < 4096; i++) begin
        logic [DATA_W-1:0] d;
        d = {32'($urandom), 32'($urandom)};
        drive(32'h5, (i == 0), ~i[0], d);
        if (!i[0]) begin
          push(11'(n), d);
          n++;
        end
        tick();
      end
    end
    chk("gate_status_done", 64'(status_out), 64'h8000_0800);

    // Re-arm in the middle of a capture
    drive(32'h0, 1'b0, 1'b0, '0);
    tick();
    drive(32'h1, 1'b0, 1'b0, '0);
    tick();
    for (int i = 0; i < 100; i++) begin
      drive(32'h0, (i == 0), 1'b0, 64'h1000 + 64'(i));
      push(11'(i), 64'h1000 + 64'(i));
      tick();
    end
    chk("mid_status_100", 64'(status_out), 64'h4000_0064);
    drive(32'h1, 1'b0, 1'b1, 64'hDEAD);
    tick();
    chk("rearm_we", 64'(bram_we), 64'(0));
    chk("rearm_status", 64'(status_out), 64'h2000_0000);
    drive(32'h1, 1'b1, 1'b1, 64'hBEEF);
    push(11'd0, 64'hBEEF);
    tick();
    chk("rearm_first_addr", 64'(bram_addr), 64'(0));
    chk("rearm_status_cap", 64'(status_out), 64'h4000_0001);

    // Reset at count 500, arm level held through release
    for (int i = 1; i < 500; i++) begin
      drive(32'h1, 1'b0, 1'b1, 64'h2000 + 64'(i));
      push(11'(i), 64'h2000 + 64'(i));
      tick();
    end
    chk("pre_rst_status", 64'(status_out), 64'h4000_01F4);
    user_rst = 1'b1;
    drive(32'h1, 1'b1, 1'b1, 64'h5A5A);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("inrst_we", 64'(bram_we), 64'(0));
      chk("inrst_addr", 64'(bram_addr), 64'(0));
      chk("inrst_din", bram_din, 64'(0));
      chk("inrst_status", 64'(status_out), 64'(0));
    end
    user_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_not_armed", 64'(status_out), 64'(0));
      chk("post_rst_we", 64'(bram_we), 64'(0));
    end
    drive(32'h0, 1'b0, 1'b0, '0);
    tick();
    drive(32'h1, 1'b0, 1'b0, '0);
    tick();
    chk("fresh_edge_arms", 64'(status_out), 64'h2000_0000);

    // Force trigger with offset 16; offset field changed after the trigger
    for (int k = 0; k < 25; k++) begin
      drive((k == 0) ? 32'h0010_0003 : 32'h0003_0001, 1'b0, 1'b0, 64'h3000 + 64'(k));
`ifdef SNAPSHOT_CAPTURE_OFFSET_EN
      if (k >= 16) push(11'(k - 16), 64'h3000 + 64'(k));
`else
      push(11'(k), 64'h3000 + 64'(k));
`endif
      tick();
`ifdef SNAPSHOT_CAPTURE_OFFSET_EN
      if (k == 0) chk("offset_status_start", 64'(status_out), 64'h4000_0000);
`else
      if (k == 0) chk("offset_status_start", 64'(status_out), 64'h4000_0001);
`endif
    end
`ifdef SNAPSHOT_CAPTURE_OFFSET_EN
    chk("offset_status_end", 64'(status_out), 64'h4000_0009);
`else
    chk("offset_status_end", 64'(status_out), 64'h4000_0019);
`endif

    user_rst = 1'b1;
    repeat (2) tick();
    user_rst = 1'b0;
    tick();
    chk("sb_drained", 64'(sb.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/snapshot_capture_ctrl.md
SNAPSHOT_CAPTURE_CTRL -- requirements
Module: snapshot_capture_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, meaning snapshot buffer depth of 2^ADDR_W words.
REQ-002 SHALL have parameter DATA_W, default 64, meaning captured word width.
REQ-003 SHALL have port user_clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port user_rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port ctrl_reg, input, 32, software control word: [0] arm, [1] force_trig, [2] valid_gate_en, [31:16] trigger offset.
REQ-006 SHALL have port trig_in, input, 1, external trigger, level-sampled.
REQ-007 SHALL have port data_valid, input, 1, qualifies din.
REQ-008 SHALL have port din, input, DATA_W, sample data.
REQ-009 SHALL have port bram_addr, output, ADDR_W, buffer write address.
REQ-010 SHALL have port bram_we, output, 1, buffer write enable.
REQ-011 SHALL have port bram_din, output, DATA_W, buffer write data.
REQ-012 SHALL have port status_out, output, 32: [31] done, [30] capturing, [29] armed, [ADDR_W:0] words written.

Function
REQ-013 SHALL implement states IDLE, ARMED, OFFSET, CAPTURE, DONE.
REQ-014 SHALL detect arm as a 0->1 transition of ctrl_reg[0] between consecutive cycles; a held level re-arms nothing.
REQ-015 SHALL, on an arm edge in any state, clear word count and done, deassert bram_we next cycle, and enter ARMED.
REQ-016 SHALL treat trigger as (trig_in | ctrl_reg[1]) and evaluate it only in ARMED; an arm edge in the same cycle takes priority and the trigger is ignored.
REQ-017 SHALL define a qualified sample as data_valid when ctrl_reg[2]=1, and every cycle when ctrl_reg[2]=0.
REQ-018 SHALL, on trigger in ARMED with offset zero (or offset compiled out), enter CAPTURE and treat the trigger cycle as the first candidate sample.
REQ-019 SHALL, in CAPTURE, register each qualified sample: bram_we=1, bram_din=din, bram_addr=count exactly one cycle after the sample cycle; count increments by 1.
REQ-020 SHALL hold bram_we=0 in all cycles without a qualified capture sample; bram_addr and bram_din hold last value.
REQ-021 SHALL enter DONE on the cycle the 2^ADDR_W-th sample is registered; count saturates at 2^ADDR_W, address never wraps; no further writes until re-armed.
REQ-022 SHALL remain in DONE indefinitely with status_out[31]=1 and count=2^ADDR_W.
REQ-023 SHALL drive status_out[30] high only in OFFSET/CAPTURE, [29] high only in ARMED; unused status bits zero.

Reset
REQ-024 SHALL, while user_rst=1, force state IDLE, count 0, bram_we 0, bram_addr 0, bram_din 0, status_out 0, arm-edge history 0.
REQ-025 SHALL abort any capture in progress on reset; no write occurs in the cycle after reset asserts.
REQ-026 SHALL, after reset release with ctrl_reg[0] already high, not arm until a fresh 0->1 edge.

Configuration
REQ-027 SHALL compile the trigger-offset feature only when macro SNAPSHOT_CAPTURE_OFFSET_EN is defined.
REQ-028 SHALL, with SNAPSHOT_CAPTURE_OFFSET_EN defined and ctrl_reg[31:16]=N>0, enter OFFSET on trigger, count N cycles (qualification ignored), then enter CAPTURE; first candidate sample is N cycles after the trigger cycle.
REQ-029 SHALL, without SNAPSHOT_CAPTURE_OFFSET_EN, ignore ctrl_reg[31:16], never enter OFFSET, and contain no offset counter.
REQ-030 SHALL sample the offset value at the trigger cycle; later ctrl_reg changes do not affect an in-progress offset.

Verification
REQ-031 SHALL verify arm edge, trig_in pulse at cycle T, data_valid=1, din=T-relative ramp -> bram_we high cycles T+1..T+2048, addr 0..2047, din 0..2047, then status_out=0x80000800.
REQ-032 SHALL verify ctrl_reg[2]=1, data_valid toggling 1/0 -> writes only on valid cycles, addresses contiguous, done after 4096 cycles.
REQ-033 SHALL verify arm edge mid-CAPTURE at count 100 -> bram_we low next cycle, status_out=0x20000000, next trigger writes address 0.
REQ-034 SHALL verify user_rst pulse at count 500 -> all outputs 0, state IDLE; holding ctrl_reg[0]=1 through release does not arm.
REQ-035 SHALL verify with SNAPSHOT_CAPTURE_OFFSET_EN, offset 16, force_trig at cycle T -> first write at T+17 carrying din of T+16; without macro first write at T+1.
